// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO pointer constants and Gray/binary helpers
//
// Purpose : default pointer width and Gray-code conversion functions shared by
//           the read and write pointer blocks.
// Contents: PTR_WIDTH_DEFAULT  default pointer width (wrap bit + address bits)
//           code_t             wide carrier type for width-independent helpers
//           bin2gray()         binary -> reflected Gray
//           gray2bin()         reflected Gray -> binary
//
// The helpers work on a 32-bit carrier so any pointer width up to 32 can use
// them: zero-extending a narrower pointer leaves its low bits converted
// correctly, and callers truncate the result back with a size cast.

package fifo_pkg;

    localparam int PTR_WIDTH_DEFAULT = 4;
    localparam int CODE_WIDTH        = 32;

    typedef logic [CODE_WIDTH-1:0] code_t;

    function automatic code_t bin2gray(input code_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic code_t gray2bin(input code_t gray);
        code_t bin;
        bin[CODE_WIDTH-1] = gray[CODE_WIDTH-1];
        for (int i = CODE_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync_2ff.sv
// rtl/gray_sync_2ff.sv - two-flop synchroniser for a Gray-coded pointer
//
// Purpose : brings a Gray pointer from a foreign clock domain into clk.
//           Only one bit of a Gray pointer changes per step, so sampling the
//           whole bus at once yields either the old or the new value.
// Ports   : clk  in   destination clock
//           rst  in   asynchronous active-high reset, clears both stages
//           d    in   WIDTH  pointer from the other domain
//           q    out  WIDTH  synchronised pointer (second stage)

module gray_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/read_ptr_block.sv
// rtl/read_ptr_block.sv - async FIFO read-domain pointer and empty-flag generator
//
// Purpose : synchronises the write Gray pointer into r_clk, advances the read
//           pointer on accepted pops and registers a conservative empty flag.
// Ports   : r_clk    in   read-domain clock
//           rrst     in   asynchronous active-high reset
//           r_en     in   pop request (ignored while empty)
//           g_wptr   in   PTR_WIDTH  Gray write pointer from the write domain
//           g_rptr   out  PTR_WIDTH  registered Gray read pointer
//           b_rptr   out  PTR_WIDTH  registered binary read pointer; low
//                                    PTR_WIDTH-1 bits are the memory address
//           empty    out  registered empty flag
//           r_level  out  PTR_WIDTH  read-side occupancy (READ_LEVEL_EN only)
// Macro   : READ_LEVEL_EN adds the r_level output and its register.

module read_ptr_block
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEFAULT
) (
    input  logic                 r_clk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH-1:0] g_wptr,
    output logic [PTR_WIDTH-1:0] g_rptr,
    output logic [PTR_WIDTH-1:0] b_rptr,
    output logic                 empty
`ifdef READ_LEVEL_EN
    ,
    output logic [PTR_WIDTH-1:0] r_level
`endif
);

    logic [PTR_WIDTH-1:0] g_wptr_sync;
    logic [PTR_WIDTH-1:0] b_rptr_next;
    logic [PTR_WIDTH-1:0] g_rptr_next;
    logic                 pop;

    gray_sync_2ff #(
        .WIDTH (PTR_WIDTH)
    ) u_wptr_sync (
        .clk (r_clk),
        .rst (rrst),
        .d   (g_wptr),
        .q   (g_wptr_sync)
    );

    // A pop while empty is silently dropped; pointers wrap modulo 2^PTR_WIDTH.
    always_comb begin
        pop         = r_en & ~empty;
        b_rptr_next = b_rptr + PTR_WIDTH'(pop);
        g_rptr_next = PTR_WIDTH'(bin2gray(code_t'(b_rptr_next)));
    end

    // Empty compares the post-pop read pointer against the synced write
    // pointer as it stood before this edge. A write landing in the
    // synchroniser on the same edge is seen one cycle late, so empty can only
    // err on the side of being asserted.
    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            b_rptr <= '0;
            g_rptr <= '0;
            empty  <= 1'b1;
        end else begin
            b_rptr <= b_rptr_next;
            g_rptr <= g_rptr_next;
            empty  <= (g_rptr_next == g_wptr_sync);
        end
    end

`ifdef READ_LEVEL_EN
    logic [PTR_WIDTH-1:0] b_wptr_sync;

    always_comb begin
        b_wptr_sync = PTR_WIDTH'(gray2bin(code_t'(g_wptr_sync)));
    end

    // Same sampling point as empty, so level and flag always agree.
    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            r_level <= '0;
        end else begin
            r_level <= b_wptr_sync - b_rptr_next;
        end
    end
`endif

endmodule

// File: tb/tb_read_ptr_block.sv
// tb/tb_read_ptr_block.sv - directed self-checking bench for read_ptr_block

module tb_read_ptr_block;

    logic       r_clk;
    logic       rrst;
    logic       r_en;
    logic [3:0] g_wptr;
    logic [3:0] g_rptr;
    logic [3:0] b_rptr;
    logic       empty;
`ifdef READ_LEVEL_EN
    logic [3:0] r_level;
`endif

    int errors;
    int checks;

    read_ptr_block #(
        .PTR_WIDTH (4)
    ) dut (
        .r_clk   (r_clk),
        .rrst    (rrst),
        .r_en    (r_en),
        .g_wptr  (g_wptr),
        .g_rptr  (g_rptr),
        .b_rptr  (b_rptr),
        .empty   (empty)
`ifdef READ_LEVEL_EN
        ,
        .r_level (r_level)
`endif
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // Pulse reset between edges and return with it released just after an edge.
    task automatic do_reset();
        @(posedge r_clk);
        #2;
        rrst = 1'b1;
        @(posedge r_clk);
        #1;
        rrst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rrst   = 1'b0;
        r_en   = 1'b0;
        g_wptr = 4'b0000;

        // Reset asserted mid-cycle clears everything without a clock edge.
        @(posedge r_clk);
        #2;
        rrst = 1'b1;
        #1;
        check("rst_g_rptr", 32'(g_rptr), 32'h0);
        check("rst_b_rptr", 32'(b_rptr), 32'h0);
        check("rst_empty",  32'(empty),  32'h1);
`ifdef READ_LEVEL_EN
        check("rst_level",  32'(r_level), 32'h0);
`endif
        @(posedge r_clk);
        #1;
        rrst = 1'b0;

        // Pops requested while empty are ignored.
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_pop_b_rptr", 32'(b_rptr), 32'h0);
            check("empty_pop_empty",  32'(empty),  32'h1);
        end
        r_en = 1'b0;

        // Write-pointer latency: empty drops on the third edge.
        g_wptr = 4'b0001;
        tick();
        check("sync_e1_empty", 32'(empty), 32'h1);
        tick();
        check("sync_e2_empty", 32'(empty), 32'h1);
        tick();
        check("sync_e3_empty", 32'(empty), 32'h0);
`ifdef READ_LEVEL_EN
        check("sync_e3_level", 32'(r_level), 32'h1);
`endif

        // Drain three entries to empty.
        do_reset();
        g_wptr = 4'b0010;
        tick();
        tick();
        check("drain_pre_empty", 32'(empty), 32'h1);
        tick();
        check("drain_sync_empty", 32'(empty), 32'h0);
`ifdef READ_LEVEL_EN
        check("drain_sync_level", 32'(r_level), 32'h3);
`endif
        r_en = 1'b1;
        tick();
        check("drain_b1", 32'(b_rptr), 32'h1);
        check("drain_e1", 32'(empty),  32'h0);
        check("drain_g1", 32'(g_rptr), 32'h1);
        tick();
        check("drain_b2", 32'(b_rptr), 32'h2);
        check("drain_e2", 32'(empty),  32'h0);
        check("drain_g2", 32'(g_rptr), 32'h3);
        tick();
        check("drain_b3", 32'(b_rptr), 32'h3);
        check("drain_e3", 32'(empty),  32'h1);
`ifdef READ_LEVEL_EN
        check("drain_level3", 32'(r_level), 32'h0);
`endif
        tick();
        check("drain_hold_b", 32'(b_rptr), 32'h3);
        check("drain_hold_e", 32'(empty),  32'h1);
        r_en = 1'b0;

        // Wrap-around: write pointer walks gray(4)..gray(15), then to 0 (16).
        for (int k = 4; k <= 15; k++) begin
            g_wptr = 4'(k ^ (k >> 1));
            tick();
        end
        tick();
        tick();
        check("wrap_fill_empty", 32'(empty), 32'h0);
`ifdef READ_LEVEL_EN
        check("wrap_fill_level", 32'(r_level), 32'd12);
`endif
        r_en = 1'b1;
        for (int k = 4; k <= 15; k++) begin
            tick();
            check("wrap_pop_b", 32'(b_rptr), 32'(k));
            check("wrap_pop_e", 32'(empty),  32'(k == 15));
        end
        check("wrap_g15", 32'(g_rptr), 32'h8);
        r_en = 1'b0;
        g_wptr = 4'b0000;
        tick();
        tick();
        tick();
        check("wrap_refill_empty", 32'(empty), 32'h0);
`ifdef READ_LEVEL_EN
        check("wrap_refill_level", 32'(r_level), 32'h1);
`endif
        r_en = 1'b1;
        tick();
        check("wrap_b0", 32'(b_rptr), 32'h0);
        check("wrap_g0", 32'(g_rptr), 32'h0);
        check("wrap_end_empty", 32'(empty), 32'h1);
        r_en = 1'b0;

        // Pessimistic empty: last pop coincides with a new pointer in stage2.
        g_wptr = 4'b0001;
        tick();
        tick();
        tick();
        check("pess_ready_empty", 32'(empty), 32'h0);
        g_wptr = 4'b0011;
        tick();
        check("pess_stage1_empty", 32'(empty), 32'h0);
        r_en = 1'b1;
        tick();
        check("pess_pop_b",     32'(b_rptr), 32'h1);
        check("pess_pop_empty", 32'(empty),  32'h1);
`ifdef READ_LEVEL_EN
        check("pess_pop_level", 32'(r_level), 32'h0);
`endif
        r_en = 1'b0;
        tick();
        check("pess_recover_empty", 32'(empty), 32'h0);
        check("pess_recover_b",     32'(b_rptr), 32'h1);
`ifdef READ_LEVEL_EN
        check("pess_recover_level", 32'(r_level), 32'h1);
`endif

        // Level scenario: write pointer binary 6, two pops.
        do_reset();
        g_wptr = 4'b0101;
        tick();
        tick();
        tick();
        check("lvl_sync_empty", 32'(empty), 32'h0);
`ifdef READ_LEVEL_EN
        check("lvl_sync_level", 32'(r_level), 32'h6);
`endif
        r_en = 1'b1;
        tick();
        tick();
        check("lvl_b2", 32'(b_rptr), 32'h2);
        check("lvl_g2", 32'(g_rptr), 32'h3);
`ifdef READ_LEVEL_EN
        check("lvl_level4", 32'(r_level), 32'h4);
`endif

        // Reset mid-operation with a pop in flight.
        #2;
        rrst = 1'b1;
        #1;
        check("midrst_b_rptr", 32'(b_rptr), 32'h0);
        check("midrst_g_rptr", 32'(g_rptr), 32'h0);
        check("midrst_empty",  32'(empty),  32'h1);
`ifdef READ_LEVEL_EN
        check("midrst_level",  32'(r_level), 32'h0);
`endif
        tick();
        check("midrst_hold_b", 32'(b_rptr), 32'h0);
        rrst = 1'b0;
        r_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
